// File: rtl/multicast_pkg.sv
// Shared types for the PE multicast transmit path: FSM states and the staged bus beat.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package multicast_pkg;

   localparam int MT_ID_BITS   = 8;
   localparam int MT_DATA_BITS = 8;

   typedef enum logic [1:0] {MT_IDLE, MT_CONFIG, MT_RUN} mt_state_t;

   typedef struct packed {
      logic [MT_ID_BITS-1:0]   tag;
      logic [MT_DATA_BITS-1:0] data;
   } mcast_beat_t;

endpackage

// File: rtl/mcast_fifo.sv
// Synchronous staging FIFO of multicast beats, head visible on pop_dat without fall-through.
// Latency: a push at edge N is visible at the head after edge N; it can be popped at edge N+1.
// Backpressure: pushes are ignored while full, pops are ignored while empty.
module mcast_fifo
   import multicast_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  mcast_beat_t push_dat,
   input  logic        pop,
   output mcast_beat_t pop_dat,
   output logic        full,
   output logic        empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   mcast_beat_t      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign pop_dat = mem[rd_ptr];

   // Pointers wrap on their own because DEPTH is a power of two; count tracks occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/multicast_tx.sv
// Multicast bus sender: programs PE IDs via one-hot strobes, then drains staged (tag,data) beats onto the bus.
// Latency: one cycle from FIFO head to registered bus; a beat accepted at edge N is on the bus at N+1 at the earliest.
// Backpressure: in_ready drops when the FIFO is full; stall_i holds the FIFO head. Optional MULTICAST_TX_STATS_EN adds counters.
module multicast_tx
   import multicast_pkg::*;
#(
   parameter int                idBits     = MT_ID_BITS,
   parameter int                dataSize   = MT_DATA_BITS,
   parameter int                numPE      = 12,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [idBits-1:0] IDLE_TAG   = '1
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_start,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [idBits-1:0]   cfg_id,
   output logic                cfg_done,
   output logic [idBits-1:0]   id_wr_data_o,
   output logic [numPE-1:0]    id_write_o,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [idBits-1:0]   in_tag,
   input  logic [dataSize-1:0] in_data,
   input  logic                stall_i,
   output logic                cast_valid_o,
   output logic [idBits-1:0]   cast_tag_o,
   output logic [dataSize-1:0] cast_data_o
`ifdef MULTICAST_TX_STATS_EN
   ,
   output logic [31:0]         stat_beats_o,
   output logic [31:0]         stat_stall_o
`endif
);

   localparam int IDX_W = (numPE > 1) ? $clog2(numPE) : 1;

   mt_state_t        state;
   mt_state_t        state_nxt;
   logic [IDX_W-1:0] idx;
   logic [numPE-1:0] idx_onehot;
   logic             last_idx;
   logic             cfg_fire;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   mcast_beat_t      in_beat;
   mcast_beat_t      head;

   assign last_idx      = (idx == IDX_W'(numPE - 1));
   assign cfg_ready     = (state == MT_CONFIG);
   assign in_ready      = ~fifo_full;
   assign in_beat.tag   = in_tag;
   assign in_beat.data  = in_data;

   mcast_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (in_valid),
      .push_dat (in_beat),
      .pop      (pop),
      .pop_dat  (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= MT_IDLE;
      else     state <= state_nxt;
   end

   // Next state, config write enable and FIFO pop; reprogramming from RUN waits for a quiet bus.
   always_comb begin
      state_nxt = state;
      cfg_fire  = 1'b0;
      pop       = 1'b0;
      case (state)
         MT_IDLE: begin
            if (cfg_start) state_nxt = MT_CONFIG;
         end
         MT_CONFIG: begin
            cfg_fire = cfg_valid;
            if (cfg_valid && last_idx) state_nxt = MT_RUN;
         end
         MT_RUN: begin
            pop = ~fifo_empty & ~stall_i;
            if (cfg_start && fifo_empty && !cast_valid_o) state_nxt = MT_CONFIG;
         end
         default: state_nxt = MT_IDLE;
      endcase
   end

   // One-hot decode of the current PE index.
   always_comb begin
      idx_onehot      = '0;
      idx_onehot[idx] = 1'b1;
   end

   // ID write strobe and data are registered for exactly one cycle per accepted cfg_id.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx          <= '0;
         id_write_o   <= '0;
         id_wr_data_o <= '0;
         cfg_done     <= 1'b0;
      end else if (cfg_fire) begin
         id_write_o   <= idx_onehot;
         id_wr_data_o <= cfg_id;
         cfg_done     <= last_idx;
         idx          <= last_idx ? '0 : idx + 1'b1;
      end else begin
         id_write_o   <= '0;
         cfg_done     <= 1'b0;
      end
   end

   // Bus register: a popped beat goes out for one cycle; IDLE_TAG beats are swallowed.
   always_ff @(posedge clk) begin
      if (rst) begin
         cast_valid_o <= 1'b0;
         cast_tag_o   <= IDLE_TAG;
         cast_data_o  <= '0;
      end else if (pop && head.tag != IDLE_TAG) begin
         cast_valid_o <= 1'b1;
         cast_tag_o   <= head.tag;
         cast_data_o  <= head.data;
      end else begin
         cast_valid_o <= 1'b0;
         cast_tag_o   <= IDLE_TAG;
         cast_data_o  <= '0;
      end
   end

`ifdef MULTICAST_TX_STATS_EN
   // Saturating counters of driven beats and stalled RUN cycles with work pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_beats_o <= '0;
         stat_stall_o <= '0;
      end else begin
         if (cast_valid_o && stat_beats_o != '1)
            stat_beats_o <= stat_beats_o + 1'b1;
         if (state == MT_RUN && !fifo_empty && stall_i && stat_stall_o != '1)
            stat_stall_o <= stat_stall_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_multicast_tx.sv
// Bench for multicast_tx: directed table, hand-written corner sequences, then random traffic against a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_multicast_tx;

   localparam int NPE   = 4;
   localparam int DEPTH = 4;
   localparam logic [7:0] IDLE = 8'hFF;
   localparam int M_IDLE = 0, M_CFG = 1, M_RUN = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0, cfg_start = 1'b0, cfg_valid = 1'b0, in_valid = 1'b0, stall_i = 1'b0;
   logic [7:0] cfg_id = '0, in_tag = '0, in_data = '0;
   logic       cfg_ready, cfg_done, in_ready, cast_valid_o;
   logic [7:0] id_wr_data_o, cast_tag_o, cast_data_o;
   logic [NPE-1:0] id_write_o;
`ifdef MULTICAST_TX_STATS_EN
   logic [31:0] stat_beats_o, stat_stall_o;
`endif

   int tests = 0;
   int fails = 0;

   // behavioural model state
   int          m_mode = M_IDLE;
   int          m_idx = 0;
   logic [15:0] m_q[$];
   logic        m_valid = 1'b0, m_done = 1'b0;
   logic [7:0]  m_tag = 8'hFF, m_data = 8'h00, m_wr_data = 8'h00;
   logic [NPE-1:0] m_wr = '0;
   int          m_beats = 0, m_stalls = 0;

   multicast_tx #(.idBits(8), .dataSize(8), .numPE(NPE), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_id(cfg_id), .cfg_done(cfg_done), .id_wr_data_o(id_wr_data_o), .id_write_o(id_write_o),
      .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_data(in_data),
      .stall_i(stall_i), .cast_valid_o(cast_valid_o), .cast_tag_o(cast_tag_o), .cast_data_o(cast_data_o)
`ifdef MULTICAST_TX_STATS_EN
      , .stat_beats_o(stat_beats_o), .stat_stall_o(stat_stall_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r, cs, cv;
      logic [7:0] cid;
      logic       iv;
      logic [7:0] it, idat;
      logic       st;
      logic       e_valid;
      logic [7:0] e_tag, e_data;
      logic [3:0] e_wr;
      logic       e_done, e_in_rdy, e_cfg_rdy;
   } vec_t;

   task automatic drive(input logic r, input logic cs, input logic cv, input logic [7:0] cid,
                        input logic iv, input logic [7:0] it, input logic [7:0] idat, input logic st);
      rst = r; cfg_start = cs; cfg_valid = cv; cfg_id = cid;
      in_valid = iv; in_tag = it; in_data = idat; stall_i = st;
   endtask

   // One clock edge of the specified behaviour, evaluated from the inputs present at the edge.
   task automatic model_step();
      int          nm;
      logic        full_pre;
      logic [15:0] b;
      if (rst) begin
         m_mode = M_IDLE; m_q.delete(); m_idx = 0;
         m_valid = 1'b0; m_tag = IDLE; m_data = 8'h00; m_wr = '0; m_done = 1'b0;
         m_beats = 0; m_stalls = 0;
         return;
      end
      full_pre = (m_q.size() == DEPTH);
      nm = m_mode;
      if (m_valid) m_beats++;
      if (m_mode == M_RUN && m_q.size() > 0 && stall_i) m_stalls++;
      m_wr = '0; m_done = 1'b0;
      if (m_mode == M_CFG && cfg_valid) begin
         m_wr = NPE'(1) << m_idx;
         m_wr_data = cfg_id;
         if (m_idx == NPE - 1) begin
            m_done = 1'b1; m_idx = 0; nm = M_RUN;
         end else m_idx++;
      end
      if (m_mode == M_IDLE && cfg_start) nm = M_CFG;
      if (m_mode == M_RUN && cfg_start && m_q.size() == 0 && !m_valid) nm = M_CFG;
      m_valid = 1'b0; m_tag = IDLE; m_data = 8'h00;
      if (m_mode == M_RUN && m_q.size() > 0 && !stall_i) begin
         b = m_q.pop_front();
         if (b[15:8] != IDLE) begin
            m_valid = 1'b1; m_tag = b[15:8]; m_data = b[7:0];
         end
      end
      if (in_valid && !full_pre) m_q.push_back({in_tag, in_data});
      m_mode = nm;
   endtask

   // Advance one clock, update the model and compare every output against it.
   task automatic tick(input string nm);
      logic bad;
      @(posedge clk);
      model_step();
      #1;
      tests++;
      bad = (cast_valid_o !== m_valid) || (cast_tag_o !== m_tag) || (cast_data_o !== m_data) ||
            (id_write_o !== m_wr) || (cfg_done !== m_done) ||
            (in_ready !== (m_q.size() < DEPTH)) || (cfg_ready !== (m_mode == M_CFG)) ||
            ((m_wr != '0) && (id_wr_data_o !== m_wr_data));
      if (bad) begin
         fails++;
         $display("FAIL %s: got v=%0b tag=%02h dat=%02h wr=%04b wd=%02h done=%0b irdy=%0b crdy=%0b; want v=%0b tag=%02h dat=%02h wr=%04b wd=%02h done=%0b irdy=%0b crdy=%0b",
                  nm, cast_valid_o, cast_tag_o, cast_data_o, id_write_o, id_wr_data_o, cfg_done, in_ready, cfg_ready,
                  m_valid, m_tag, m_data, m_wr, m_wr_data, m_done, (m_q.size() < DEPTH), (m_mode == M_CFG));
      end
`ifdef MULTICAST_TX_STATS_EN
      tests++;
      if (stat_beats_o !== 32'(m_beats) || stat_stall_o !== 32'(m_stalls)) begin
         fails++;
         $display("FAIL %s stats: got beats=%0d stalls=%0d want beats=%0d stalls=%0d",
                  nm, stat_beats_o, stat_stall_o, m_beats, m_stalls);
      end
`endif
   endtask

   task automatic expect_bus(input string nm, input logic v, input logic [7:0] t, input logic [7:0] d);
      tests++;
      if (cast_valid_o !== v || cast_tag_o !== t || cast_data_o !== d) begin
         fails++;
         $display("FAIL %s: got v=%0b tag=%02h dat=%02h want v=%0b tag=%02h dat=%02h",
                  nm, cast_valid_o, cast_tag_o, cast_data_o, v, t, d);
      end
   endtask

   task automatic expect_bit(input string nm, input logic got, input logic want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0b want %0b", nm, got, want);
      end
   endtask

   task automatic program_ids();
      drive(0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0); tick("cfg_start");
      for (int i = 0; i < NPE; i++) begin
         drive(0, 0, 1, 8'(8'h40 + i), 0, 8'h00, 8'h00, 0);
         tick("cfg_id");
      end
      drive(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0);
   endtask

   vec_t tbl[10];

   initial begin
      // Test 1 (program IDs 3,5,7,9) and test 2 (two back-to-back beats).
      tbl[0] = '{1,0,0,8'h00, 0,8'h00,8'h00, 0,  0,8'hFF,8'h00,4'b0000,0,1,0};
      tbl[1] = '{0,1,0,8'h00, 0,8'h00,8'h00, 0,  0,8'hFF,8'h00,4'b0000,0,1,1};
      tbl[2] = '{0,0,1,8'h03, 0,8'h00,8'h00, 0,  0,8'hFF,8'h00,4'b0001,0,1,1};
      tbl[3] = '{0,0,1,8'h05, 0,8'h00,8'h00, 0,  0,8'hFF,8'h00,4'b0010,0,1,1};
      tbl[4] = '{0,0,1,8'h07, 0,8'h00,8'h00, 0,  0,8'hFF,8'h00,4'b0100,0,1,1};
      tbl[5] = '{0,0,1,8'h09, 0,8'h00,8'h00, 0,  0,8'hFF,8'h00,4'b1000,1,1,0};
      tbl[6] = '{0,0,0,8'h00, 1,8'h05,8'hAA, 0,  0,8'hFF,8'h00,4'b0000,0,1,0};
      tbl[7] = '{0,0,0,8'h00, 1,8'h09,8'h55, 0,  1,8'h05,8'hAA,4'b0000,0,1,0};
      tbl[8] = '{0,0,0,8'h00, 0,8'h00,8'h00, 0,  1,8'h09,8'h55,4'b0000,0,1,0};
      tbl[9] = '{0,0,0,8'h00, 0,8'h00,8'h00, 0,  0,8'hFF,8'h00,4'b0000,0,1,0};

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].r, tbl[i].cs, tbl[i].cv, tbl[i].cid, tbl[i].iv, tbl[i].it, tbl[i].idat, tbl[i].st);
         tick($sformatf("vec%0d_model", i));
         tests++;
         if (cast_valid_o !== tbl[i].e_valid || cast_tag_o !== tbl[i].e_tag || cast_data_o !== tbl[i].e_data ||
             id_write_o !== tbl[i].e_wr || cfg_done !== tbl[i].e_done || in_ready !== tbl[i].e_in_rdy ||
             cfg_ready !== tbl[i].e_cfg_rdy || (tbl[i].e_wr != 0 && id_wr_data_o !== tbl[i].cid)) begin
            fails++;
            $display("FAIL vec%0d: got v=%0b tag=%02h dat=%02h wr=%04b wd=%02h done=%0b irdy=%0b crdy=%0b want v=%0b tag=%02h dat=%02h wr=%04b wd=%02h done=%0b irdy=%0b crdy=%0b",
                     i, cast_valid_o, cast_tag_o, cast_data_o, id_write_o, id_wr_data_o, cfg_done, in_ready, cfg_ready,
                     tbl[i].e_valid, tbl[i].e_tag, tbl[i].e_data, tbl[i].e_wr, tbl[i].cid, tbl[i].e_done,
                     tbl[i].e_in_rdy, tbl[i].e_cfg_rdy);
         end
      end

      // Test 3: fill under stall, reject a 5th push, drain in order.
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 8'h00, 1, 8'(i + 1), 8'(8'h10 + i), 1);
         tick("fill");
         expect_bus("fill_idle", 0, IDLE, 8'h00);
      end
      expect_bit("full_in_ready", in_ready, 1'b0);
      drive(0, 0, 0, 8'h00, 1, 8'h77, 8'h77, 1); tick("push_full");
      expect_bit("still_full", in_ready, 1'b0);
      drive(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0);
      for (int i = 0; i < DEPTH; i++) begin
         tick("drain");
         expect_bus($sformatf("drain%0d", i), 1, 8'(i + 1), 8'(8'h10 + i));
      end
      tick("after_drain");
      expect_bus("no_5th_beat", 0, IDLE, 8'h00);

      // Test 4: IDLE_TAG beat between two real beats leaves a one-cycle gap.
      drive(0, 0, 0, 8'h00, 1, 8'h01, 8'hA1, 0); tick("t4a");
      expect_bus("t4_empty", 0, IDLE, 8'h00);
      drive(0, 0, 0, 8'h00, 1, IDLE, 8'h00, 0); tick("t4b");
      expect_bus("t4_first", 1, 8'h01, 8'hA1);
      drive(0, 0, 0, 8'h00, 1, 8'h02, 8'hA2, 0); tick("t4c");
      expect_bus("t4_gap", 0, IDLE, 8'h00);
      drive(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0); tick("t4d");
      expect_bus("t4_second", 1, 8'h02, 8'hA2);
      tick("t4e");

      // Test 5: cfg_start ignored with queued beats; reset mid-stream flushes everything.
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 8'h00, 1, 8'(8'h21 + i), 8'(8'h30 + i), 1);
         tick("t5_fill");
      end
      drive(0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 1); tick("t5_cfg_ignored");
      expect_bit("cfg_start_ignored", cfg_ready, 1'b0);
      drive(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0); tick("t5_one_out");
      expect_bus("t5_beat_on_bus", 1, 8'h21, 8'h30);
      drive(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0); tick("t5_rst");
      expect_bus("rst_bus_idle", 0, IDLE, 8'h00);
      expect_bit("rst_in_ready", in_ready, 1'b1);
      drive(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0); tick("t5_idle");
      expect_bus("idle_no_pop", 0, IDLE, 8'h00);
      program_ids();
      tick("t5_run0");
      tick("t5_run1");
      expect_bus("fifo_flushed", 0, IDLE, 8'h00);

      // Randomised traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         logic [7:0] t;
         t = ($urandom_range(0, 7) == 0) ? IDLE : 8'($urandom_range(0, 254));
         drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
               8'($urandom_range(0, 254)), ($urandom_range(0, 9) < 6), t, 8'($urandom),
               ($urandom_range(0, 9) < 3));
         tick("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
